// File: rtl/counter10_seq_ctrl.sv
// ---------------------------------------------------------------------------
// counter10_seq_ctrl
//   Sequencer for a cascaded chain of DIGITS decade (BCD) counters that share
//   this block's clock. A run presets the chain for one cycle. It then issues
//   single-cycle count enables, one every PRESCALE clocks. The run finishes
//   when the chain value fed back on cnt_q equals the programmed BCD limit.
//   A run can be paused with hold and abandoned with abort or clr.
//
// Handshake / strobe semantics:
//   start and abort are single-cycle pulses and are sampled on the rising
//   edge. hold is a level. cnt_load and cnt_en are single-cycle strobes that
//   the chain acts on at the same rising edge. The two strobes are mutually
//   exclusive: cnt_load only occurs in LOAD, and cnt_en only occurs in RUN.
//
// Ports:
//   clk       in   system clock, rising edge
//   clr       in   asynchronous active-high reset
//   start     in   begin a run (honoured in IDLE and DONE)
//   hold      in   pause counting while high (RUN/PAUSE)
//   abort     in   return to IDLE from any state
//   preset    in   BCD start value, sampled in LOAD
//   limit     in   BCD terminal value, compared in RUN
//   cnt_q     in   current BCD value from the counter chain
//   cnt_load  out  chain load strobe
//   cnt_en    out  chain increment strobe
//   cnt_data  out  sanitised preset (0 outside LOAD)
//   busy      out  high in LOAD, RUN, PAUSE
//   done      out  high in DONE
//   state     out  debug state code: IDLE=0 LOAD=1 RUN=2 PAUSE=3 DONE=4
// ---------------------------------------------------------------------------
module counter10_seq_ctrl #(
    parameter int DIGITS   = 2,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  start,
    input  logic                  hold,
    input  logic                  abort,
    input  logic [4*DIGITS-1:0]   preset,
    input  logic [4*DIGITS-1:0]   limit,
    input  logic [4*DIGITS-1:0]   cnt_q,
    output logic                  cnt_load,
    output logic                  cnt_en,
    output logic [4*DIGITS-1:0]   cnt_data,
    output logic                  busy,
    output logic                  done,
    output logic [2:0]            state
);

    localparam int              PW      = $clog2(PRESCALE);
    localparam logic [PW-1:0]   PS_LAST = PW'(PRESCALE - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        pre_q, pre_d;
    logic [4*DIGITS-1:0]  preset_san;
    logic                 limit_ok;
    logic                 match;

    // A preset digit above 9 is illegal for a decade counter, so it is loaded as 0.
    // A limit digit above 9 can never appear on cnt_q. Such a limit is therefore
    // flagged explicitly and never produces a match.
    always_comb begin
        preset_san = '0;
        limit_ok   = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            preset_san[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd0 : preset[4*i +: 4];
            if (limit[4*i +: 4] > 4'd9) begin
                limit_ok = 1'b0;
            end
        end
    end

    assign match = limit_ok && (cnt_q == limit);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= S_IDLE;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
        end
    end

    // Priority everywhere: abort > limit match > hold > start.
    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_data = '0;
        case (state_q)
            S_IDLE: begin
                pre_d = '0;
                if (!abort && start) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_load = 1'b1;
                cnt_data = preset_san;
                pre_d    = '0;
                state_d  = abort ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (match) begin
                    state_d = S_DONE;
                end else if (hold) begin
                    // The prescaler is frozen so a partial tick survives the pause.
                    state_d = S_PAUSE;
                end else begin
                    cnt_en = (pre_q == PS_LAST);
                    pre_d  = (pre_q == PS_LAST) ? '0 : pre_q + 1'b1;
                end
            end
            S_PAUSE: begin
                if (abort) begin
                    state_d = S_IDLE;
                    pre_d   = '0;
                end else if (!hold) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (start) begin
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
                pre_d   = '0;
            end
        endcase
    end

    assign busy  = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSE);
    assign done  = (state_q == S_DONE);
    assign state = state_q;

endmodule

// File: tb/tb_counter10_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_counter10_seq_ctrl
//   Drives the sequencer together with a two-digit decade counter chain.
//   Each run is recorded one cycle at a time. The recording is compared
//   against a timing model that works from active-cycle arithmetic:
//   - pulse k falls on active RUN cycle k*P;
//   - the match is seen on active cycle N*P+1;
//   - a hold of H cycles stalls progress by H+1 cycles.
// ---------------------------------------------------------------------------
module tb_counter10_seq_ctrl;

  localparam int P   = 4;
  localparam int MAX = 512;

  logic       clk = 1'b0;
  logic       clr, start, hold, abort;
  logic [7:0] preset, limit, cnt_q, cnt_data;
  logic       cnt_load, cnt_en, busy, done;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  counter10_seq_ctrl #(.DIGITS(2), .PRESCALE(P)) dut (
    .clk(clk), .clr(clr), .start(start), .hold(hold), .abort(abort),
    .preset(preset), .limit(limit), .cnt_q(cnt_q),
    .cnt_load(cnt_load), .cnt_en(cnt_en), .cnt_data(cnt_data),
    .busy(busy), .done(done), .state(state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // two-digit decade counter chain
  logic [3:0] d0, d1;
  assign cnt_q = {d1, d0};
  always @(posedge clk or posedge clr) begin
    if (clr) begin
      d0 <= 4'd0;
      d1 <= 4'd0;
    end else if (cnt_load) begin
      d0 <= cnt_data[3:0];
      d1 <= cnt_data[7:4];
    end else if (cnt_en) begin
      if (d0 == 4'd9) begin
        d0 <= 4'd0;
        d1 <= (d1 == 4'd9) ? 4'd0 : d1 + 4'd1;
      end else begin
        d0 <= d0 + 4'd1;
      end
    end
  end

  // recorded trace (index 0 = LOAD cycle)
  logic [2:0] tr_state [MAX];
  logic       tr_en    [MAX];
  logic       tr_load  [MAX];
  logic       tr_busy  [MAX];
  logic       tr_done  [MAX];
  logic [7:0] tr_data  [MAX];
  logic [7:0] tr_q     [MAX];

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       ld;
    logic [7:0] data;
    logic       bz;
    logic       dn;
    logic [7:0] q;
  } exp_t;

  // ---------------- reference model ----------------
  function automatic logic [7:0] san(input logic [7:0] b);
    logic [3:0] hi, lo;
    hi = (b[7:4] > 4'd9) ? 4'd0 : b[7:4];
    lo = (b[3:0] > 4'd9) ? 4'd0 : b[3:0];
    return {hi, lo};
  endfunction

  function automatic bit valid(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic int to_int(input logic [7:0] b);
    return 10 * int'(b[7:4]) + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] to_bcd(input int v);
    logic [3:0] hi, lo;
    hi = 4'((v / 10) % 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  // Expected observation at cycle c of a run.
  //   hs/hl : hold window start and length (hl=0 means no hold)
  //   ab    : abort cycle (-1 means none)
  function automatic exp_t model(input int c, input logic [7:0] pre, input logic [7:0] lim,
                                 input int hs, input int hl, input int ab);
    exp_t e;
    int p, n, last, act_b, act, pulses;
    bit win;
    e = '0;
    p = to_int(san(pre));
    n = valid(lim) ? (to_int(lim) - p + 100) % 100 : 100000;
    if (c == 0) begin
      e.st = 3'd1; e.ld = 1'b1; e.data = san(pre); e.bz = 1'b1;
      return e;
    end
    last = (ab >= 1 && ab < c) ? ab : c - 1;
    act_b = 0;
    for (int i = 1; i <= last; i++) begin
      if (!(hl > 0 && i >= hs && i <= hs + hl)) act_b++;
    end
    pulses = act_b / P;
    if (pulses > n) pulses = n;
    e.q = to_bcd((p + pulses) % 100);
    if (ab >= 1 && c > ab) return e;
    win = (hl > 0 && c >= hs && c <= hs + hl);
    act = act_b + (win ? 0 : 1);
    if (!win && act > n * P + 1) begin
      e.st = 3'd4; e.dn = 1'b1;
    end else begin
      e.st = (win && c != hs) ? 3'd3 : 3'd2;
      e.bz = 1'b1;
      e.en = !win && (act % P == 0) && (act <= n * P) && (c != ab);
    end
    return e;
  endfunction

  function automatic exp_t observed(input int c);
    exp_t o;
    o.st = tr_state[c]; o.en = tr_en[c]; o.ld = tr_load[c]; o.data = tr_data[c];
    o.bz = tr_busy[c];  o.dn = tr_done[c];
    o.q  = (c == 0) ? 8'h00 : tr_q[c];
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic run_trace(input logic [7:0] pre, input logic [7:0] lim, input int hs,
                           input int hl, input int ab, input int st_at, input int len);
    @(posedge clk); #1;
    preset = pre; limit = lim; start = 1'b1; hold = 1'b0; abort = 1'b0;
    for (int c = 0; c < len; c++) begin
      @(posedge clk); #1;
      start = (c == st_at) || (c == ab);
      hold  = (hl > 0 && c >= hs && c < hs + hl);
      abort = (c == ab);
      @(negedge clk);
      tr_state[c] = state; tr_en[c] = cnt_en; tr_load[c] = cnt_load;
      tr_data[c]  = cnt_data; tr_busy[c] = busy; tr_done[c] = done; tr_q[c] = cnt_q;
    end
    @(posedge clk); #1;
    start = 1'b0; hold = 1'b0; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clr = 1'b1; start = 1'b0; hold = 1'b0; abort = 1'b0; preset = 8'h00; limit = 8'h00;
    #2;
    total++;
    if ({state, cnt_load, cnt_en, cnt_data, busy, done} !== 15'd0) begin
      bad++;
      $display("FAIL reset got st=%0d ld=%0b en=%0b data=%h busy=%0b done=%0b want all 0",
               state, cnt_load, cnt_en, cnt_data, busy, done);
    end
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic test_basic();
    exp_t e, o;
    int npulse = 0;
    run_trace(8'h07, 8'h12, 0, 0, -1, -1, 26);
    for (int c = 0; c < 26; c++) begin
      e = model(c, 8'h07, 8'h12, 0, 0, -1);
      o = observed(c);
      if (o.en) npulse++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL basic c=%0d got st=%0d en=%0b ld=%0b data=%h bz=%0b dn=%0b q=%h want st=%0d en=%0b ld=%0b data=%h bz=%0b dn=%0b q=%h",
                 c, o.st, o.en, o.ld, o.data, o.bz, o.dn, o.q, e.st, e.en, e.ld, e.data, e.bz, e.dn, e.q);
      end
    end
    total++;
    if (npulse !== 5) begin bad++; $display("FAIL basic_pulses got %0d want 5", npulse); end
    total++;
    if (tr_q[22] !== 8'h12 || tr_done[22] !== 1'b1) begin
      bad++; $display("FAIL basic_final got q=%h done=%0b want q=12 done=1", tr_q[22], tr_done[22]);
    end
  endtask

  task automatic test_hold();
    exp_t e, o;
    run_trace(8'h07, 8'h12, 2 * P + 1, 10, -1, -1, 37);
    for (int c = 0; c < 37; c++) begin
      e = model(c, 8'h07, 8'h12, 2 * P + 1, 10, -1);
      o = observed(c);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL hold c=%0d got st=%0d en=%0b q=%h dn=%0b want st=%0d en=%0b q=%h dn=%0b",
                 c, o.st, o.en, o.q, o.dn, e.st, e.en, e.q, e.dn);
      end
    end
  endtask

  task automatic test_equal();
    exp_t e, o;
    int npulse = 0;
    run_trace(8'h45, 8'h45, 0, 0, -1, -1, 6);
    for (int c = 0; c < 6; c++) begin
      e = model(c, 8'h45, 8'h45, 0, 0, -1);
      o = observed(c);
      if (o.en) npulse++;
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL equal c=%0d got st=%0d en=%0b q=%h want st=%0d en=%0b q=%h",
                 c, o.st, o.en, o.q, e.st, e.en, e.q);
      end
    end
    total++;
    if (npulse !== 0) begin bad++; $display("FAIL equal_pulses got %0d want 0", npulse); end
  endtask

  task automatic test_wrap();
    exp_t e, o;
    run_trace(8'h98, 8'h01, 0, 0, -1, -1, 18);
    for (int c = 0; c < 18; c++) begin
      e = model(c, 8'h98, 8'h01, 0, 0, -1);
      o = observed(c);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL wrap c=%0d got st=%0d en=%0b q=%h want st=%0d en=%0b q=%h",
                 c, o.st, o.en, o.q, e.st, e.en, e.q);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e, o;
    // a start pulse in RUN cycle 3 must be ignored; abort+start follows the 2nd pulse
    run_trace(8'h20, 8'h50, 0, 0, 2 * P + 1, 3, 16);
    for (int c = 0; c < 16; c++) begin
      e = model(c, 8'h20, 8'h50, 0, 0, 2 * P + 1);
      o = observed(c);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL abort c=%0d got st=%0d en=%0b ld=%0b bz=%0b q=%h want st=%0d en=%0b ld=%0b bz=%0b q=%h",
                 c, o.st, o.en, o.ld, o.bz, o.q, e.st, e.en, e.ld, e.bz, e.q);
      end
    end
  endtask

  task automatic test_bad_limit();
    exp_t e, o;
    // preset tens digit B loads as 0; limit digit A never matches
    run_trace(8'hB3, 8'h3A, 0, 0, -1, -1, 30);
    for (int c = 0; c < 30; c++) begin
      e = model(c, 8'hB3, 8'h3A, 0, 0, -1);
      o = observed(c);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL bad_limit c=%0d got st=%0d en=%0b data=%h q=%h want st=%0d en=%0b data=%h q=%h",
                 c, o.st, o.en, o.data, o.q, e.st, e.en, e.data, e.q);
      end
    end
  endtask

  task automatic test_clr();
    exp_t e, o;
    @(posedge clk); #1;
    preset = 8'h33; limit = 8'h60; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #2 clr = 1'b1;
    #1;
    total++;
    if ({state, cnt_load, cnt_en, cnt_data, busy, done} !== 15'd0) begin
      bad++;
      $display("FAIL clr_async got st=%0d ld=%0b en=%0b data=%h busy=%0b done=%0b want all 0",
               state, cnt_load, cnt_en, cnt_data, busy, done);
    end
    #1 clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (state !== 3'd0 || cnt_load !== 1'b0 || cnt_en !== 1'b0) begin
        bad++;
        $display("FAIL clr_idle i=%0d got st=%0d ld=%0b en=%0b want st=0 ld=0 en=0", i, state, cnt_load, cnt_en);
      end
    end
    run_trace(8'h56, 8'h58, 0, 0, -1, -1, 14);
    for (int c = 0; c < 14; c++) begin
      e = model(c, 8'h56, 8'h58, 0, 0, -1);
      o = observed(c);
      total++;
      if (o !== e) begin
        bad++;
        $display("FAIL clr_restart c=%0d got st=%0d en=%0b data=%h q=%h want st=%0d en=%0b data=%h q=%h",
                 c, o.st, o.en, o.data, o.q, e.st, e.en, e.data, e.q);
      end
    end
  endtask

  task automatic test_random();
    exp_t e, o;
    logic [7:0] pre, lim;
    int n, hs, hl, len;
    for (int it = 0; it < 8; it++) begin
      pre = to_bcd($urandom_range(0, 99));
      n   = $urandom_range(0, 12);
      lim = to_bcd((to_int(pre) + n) % 100);
      hl  = (n > 0) ? $urandom_range(1, 6) : 0;
      hs  = (n > 0) ? $urandom_range(1, n * P) : 0;
      len = n * P + 2 + ((hl > 0) ? hl + 1 : 0) + 3;
      run_trace(pre, lim, hs, hl, -1, -1, len);
      for (int c = 0; c < len; c++) begin
        e = model(c, pre, lim, hs, hl, -1);
        o = observed(c);
        total++;
        if (o !== e) begin
          bad++;
          $display("FAIL random it=%0d pre=%h lim=%h hs=%0d hl=%0d c=%0d got st=%0d en=%0b q=%h want st=%0d en=%0b q=%h",
                   it, pre, lim, hs, hl, c, o.st, o.en, o.q, e.st, e.en, e.q);
        end
      end
    end
  endtask

  // ---------------- sequence + final report ----------------
  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_equal();
    test_wrap();
    test_abort();
    test_bad_limit();
    test_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
